// File: rtl/sram_ctrl.sv
// 32-bit LSU port onto a 16-bit asynchronous SRAM: each word is two halfword
// cycles, and each write halfword is a strobe cycle followed by a hold cycle.
module sram_ctrl (
   input  logic        i_clk,
   input  logic        i_rstn,
   input  logic        i_req,
   input  logic        i_wren,
   input  logic [18:0] i_addr,
   input  logic [3:0]  i_bmask,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_rdata,
   output logic        o_ready,
   output logic        o_ack,
   output logic [17:0] o_sram_addr,
   inout  wire  [15:0] io_sram_dq,
   output logic        o_sram_ce_n,
   output logic        o_sram_oe_n,
   output logic        o_sram_we_n,
   output logic        o_sram_lb_n,
   output logic        o_sram_ub_n
);

   typedef enum logic [2:0] {
      IDLE, RD_LO, RD_HI, WR_LO, WR_LO_H, WR_HI, WR_HI_H, DONE
   } state_t;

   state_t      state, state_next;
   logic [16:0] addr_reg;
   logic [3:0]  bmask_reg;
   logic [31:0] wdata_reg;
   logic [16:0] eff_addr;
   logic [3:0]  eff_bmask;
   logic [31:0] eff_wdata;
   logic        ce_next, oe_next, we_next, lb_next, ub_next, ack_next;
   logic        dq_oe_next, dq_oe_reg;
   logic [17:0] sram_addr_next;
   logic [15:0] dq_out_next, dq_out_reg;
   logic        unused_addr_lsbs;

   assign unused_addr_lsbs = ^i_addr[1:0];
   assign o_ready    = (state == IDLE);
   assign io_sram_dq = dq_oe_reg ? dq_out_reg : 16'hzzzz;

   // Pins are registered from the next state, so in IDLE the request fields
   // must come straight from the inputs rather than the latched copies.
   assign eff_addr  = o_ready ? i_addr[18:2] : addr_reg;
   assign eff_bmask = o_ready ? i_bmask      : bmask_reg;
   assign eff_wdata = o_ready ? i_wdata      : wdata_reg;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) state <= IDLE;
      else         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (i_req) begin
               if (!i_wren)             state_next = RD_LO;
               else if (|i_bmask[1:0])  state_next = WR_LO;
               else if (|i_bmask[3:2])  state_next = WR_HI;
               else                     state_next = DONE;
            end
         end
         RD_LO:   state_next = RD_HI;
         RD_HI:   state_next = DONE;
         WR_LO:   state_next = WR_LO_H;
         WR_LO_H: state_next = (|bmask_reg[3:2]) ? WR_HI : DONE;
         WR_HI:   state_next = WR_HI_H;
         WR_HI_H: state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      ce_next        = 1'b1;
      oe_next        = 1'b1;
      we_next        = 1'b1;
      lb_next        = 1'b1;
      ub_next        = 1'b1;
      ack_next       = 1'b0;
      dq_oe_next     = 1'b0;
      dq_out_next    = dq_out_reg;
      sram_addr_next = o_sram_addr;
      case (state_next)
         RD_LO, RD_HI: begin
            ce_next        = 1'b0;
            oe_next        = 1'b0;
            lb_next        = 1'b0;
            ub_next        = 1'b0;
            sram_addr_next = {eff_addr, (state_next == RD_HI)};
         end
         WR_LO, WR_LO_H: begin
            ce_next        = 1'b0;
            we_next        = (state_next != WR_LO);
            lb_next        = ~eff_bmask[0];
            ub_next        = ~eff_bmask[1];
            dq_oe_next     = 1'b1;
            dq_out_next    = eff_wdata[15:0];
            sram_addr_next = {eff_addr, 1'b0};
         end
         WR_HI, WR_HI_H: begin
            ce_next        = 1'b0;
            we_next        = (state_next != WR_HI);
            lb_next        = ~eff_bmask[2];
            ub_next        = ~eff_bmask[3];
            dq_oe_next     = 1'b1;
            dq_out_next    = eff_wdata[31:16];
            sram_addr_next = {eff_addr, 1'b1};
         end
         DONE:    ack_next = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         o_sram_ce_n <= 1'b1;
         o_sram_oe_n <= 1'b1;
         o_sram_we_n <= 1'b1;
         o_sram_lb_n <= 1'b1;
         o_sram_ub_n <= 1'b1;
         o_sram_addr <= '0;
         o_ack       <= 1'b0;
         dq_oe_reg   <= 1'b0;
         dq_out_reg  <= '0;
      end else begin
         o_sram_ce_n <= ce_next;
         o_sram_oe_n <= oe_next;
         o_sram_we_n <= we_next;
         o_sram_lb_n <= lb_next;
         o_sram_ub_n <= ub_next;
         o_sram_addr <= sram_addr_next;
         o_ack       <= ack_next;
         dq_oe_reg   <= dq_oe_next;
         dq_out_reg  <= dq_out_next;
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         addr_reg  <= '0;
         bmask_reg <= '0;
         wdata_reg <= '0;
         o_rdata   <= '0;
      end else begin
         if (o_ready && i_req) begin
            addr_reg  <= i_addr[18:2];
            bmask_reg <= i_bmask;
            wdata_reg <= i_wdata;
         end
         if (state == RD_LO) o_rdata[15:0]  <= io_sram_dq;
         if (state == RD_HI) o_rdata[31:16] <= io_sram_dq;
      end
   end

endmodule
